// File: rtl/FPALL_pkg.sv
// Shared formats and widths for the FP alignment datapath.
// FP16x2 packs two independent 14b lanes into the 28b fraction: hi = [27:14], lo = [13:0].
package FPALL_pkg;

  localparam int FRAC_W  = 28;
  localparam int LANE_W  = 14;
  localparam int SHAMT_W = 5;
  localparam int FINE_W  = 3;
  localparam int SPILL_W = (1 << SHAMT_W) - 1;

  typedef enum logic {
    FP32   = 1'b0,
    FP16X2 = 1'b1
  } fp_fmt_e;

  // Stage 1 applies the 16/8 weights of the shift, stage 2 the 4/2/1 residue.
  localparam logic [SHAMT_W-1:0] COARSE_MSK = 5'b11000;

  function automatic logic [SHAMT_W-1:0] fine_amt(input logic [FINE_W-1:0] res);
    return {{(SHAMT_W-FINE_W){1'b0}}, res};
  endfunction

endpackage

// File: rtl/rshift_sticky14.sv
// Combinational 14b logical right shift with zero fill; sticky is the OR of every bit pushed out.
// Shifts of 14..31 clear the lane and fold the whole lane into sticky.
module rshift_sticky14
  import FPALL_pkg::*;
(
  input  logic [LANE_W-1:0]  d,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [LANE_W-1:0]  q,
  output logic               sticky
);

  localparam int EXT_W = LANE_W + SPILL_W;

  logic [EXT_W-1:0] ext;

  // The spill field is wide enough to catch every bit even at the maximum shift.
  assign ext    = {d, {SPILL_W{1'b0}}} >> shamt;
  assign q      = ext[EXT_W-1 -: LANE_W];
  assign sticky = |ext[SPILL_W-1:0];

endmodule

// File: rtl/align_shifter.sv
// Two-stage fraction aligner (FP32 or 2x FP16 lanes), latency 2, one result per cycle.
// Valid/ready pipe: a stage refills whenever its downstream slot frees; outputs hold while stalled.
module align_shifter
  import FPALL_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  fp_fmt_e            fmt,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FRAC_W-1:0]  X,
  input  logic [SHAMT_W-1:0] Shift_h,
  input  logic [SHAMT_W-1:0] Shift_l,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FRAC_W-1:0]  R,
  output logic               Sticky_h,
  output logic               Sticky_l
);

  localparam int EXT32_W = FRAC_W + SPILL_W;

  logic s1_load;
  logic s2_load;

  logic              s1_valid;
  fp_fmt_e           s1_fmt;
  logic [FRAC_W-1:0] s1_d;
  logic [FINE_W-1:0] s1_res_h;
  logic [FINE_W-1:0] s1_res_l;
  logic              s1_st_h;
  logic              s1_st_l;

  logic              s2_valid;
  logic [FRAC_W-1:0] s2_r;
  logic              s2_st_h;
  logic              s2_st_l;

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // ---------------- stage 1: coarse shift ----------------
  logic [EXT32_W-1:0] c32_ext;
  logic [LANE_W-1:0]  c_hi_q;
  logic [LANE_W-1:0]  c_lo_q;
  logic               c_hi_st;
  logic               c_lo_st;

  assign c32_ext = {X, {SPILL_W{1'b0}}} >> (Shift_l & COARSE_MSK);

  rshift_sticky14 u_coarse_hi (
    .d      (X[FRAC_W-1:LANE_W]),
    .shamt  (Shift_h & COARSE_MSK),
    .q      (c_hi_q),
    .sticky (c_hi_st)
  );

  rshift_sticky14 u_coarse_lo (
    .d      (X[LANE_W-1:0]),
    .shamt  (Shift_l & COARSE_MSK),
    .q      (c_lo_q),
    .sticky (c_lo_st)
  );

  logic [FRAC_W-1:0] s1_d_nxt;
  logic              s1_st_h_nxt;
  logic              s1_st_l_nxt;

  always_comb begin
    s1_d_nxt    = {c_hi_q, c_lo_q};
    s1_st_h_nxt = c_hi_st;
    s1_st_l_nxt = c_lo_st;
    if (fmt == FP32) begin
      s1_d_nxt    = c32_ext[EXT32_W-1 -: FRAC_W];
      s1_st_h_nxt = 1'b0;
      s1_st_l_nxt = |c32_ext[SPILL_W-1:0];
    end
  end

  // ---------------- stage 2: fine shift ----------------
  logic [EXT32_W-1:0] f32_ext;
  logic [LANE_W-1:0]  f_hi_q;
  logic [LANE_W-1:0]  f_lo_q;
  logic               f_hi_st;
  logic               f_lo_st;

  assign f32_ext = {s1_d, {SPILL_W{1'b0}}} >> fine_amt(s1_res_l);

  rshift_sticky14 u_fine_hi (
    .d      (s1_d[FRAC_W-1:LANE_W]),
    .shamt  (fine_amt(s1_res_h)),
    .q      (f_hi_q),
    .sticky (f_hi_st)
  );

  rshift_sticky14 u_fine_lo (
    .d      (s1_d[LANE_W-1:0]),
    .shamt  (fine_amt(s1_res_l)),
    .q      (f_lo_q),
    .sticky (f_lo_st)
  );

  logic [FRAC_W-1:0] s2_r_nxt;
  logic              s2_st_h_nxt;
  logic              s2_st_l_nxt;

  always_comb begin
    s2_r_nxt    = {f_hi_q, f_lo_q};
    s2_st_h_nxt = s1_st_h | f_hi_st;
    s2_st_l_nxt = s1_st_l | f_lo_st;
    if (s1_fmt == FP32) begin
      s2_r_nxt    = f32_ext[EXT32_W-1 -: FRAC_W];
      s2_st_h_nxt = 1'b0;
      s2_st_l_nxt = s1_st_l | (|f32_ext[SPILL_W-1:0]);
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_fmt   <= FP32;
      s1_d     <= '0;
      s1_res_h <= '0;
      s1_res_l <= '0;
      s1_st_h  <= 1'b0;
      s1_st_l  <= 1'b0;
      s2_valid <= 1'b0;
      s2_r     <= '0;
      s2_st_h  <= 1'b0;
      s2_st_l  <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_fmt   <= fmt;
          s1_d     <= s1_d_nxt;
          s1_res_h <= Shift_h[FINE_W-1:0];
          s1_res_l <= Shift_l[FINE_W-1:0];
          s1_st_h  <= s1_st_h_nxt;
          s1_st_l  <= s1_st_l_nxt;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_r    <= s2_r_nxt;
          s2_st_h <= s2_st_h_nxt;
          s2_st_l <= s2_st_l_nxt;
        end
      end
    end
  end

  // Reset masks the outputs in the same cycle so nothing stale can hand off while rst is high.
  assign out_valid = s2_valid & ~rst;
  assign R         = rst ? '0 : s2_r;
  assign Sticky_h  = s2_st_h & ~rst;
  assign Sticky_l  = s2_st_l & ~rst;

  a_hold_r : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> ($stable(R) && $stable(Sticky_h) && $stable(Sticky_l)));

  a_fp32_sticky_h : assert property (@(posedge clk) disable iff (rst)
    (s2_valid && s1_fmt == FP32 && s2_load && s1_valid) |=> !s2_st_h);

endmodule

// File: tb/tb_align_shifter.sv
// Bench for align_shifter: directed corner cases plus a random mixed-format stream
// scored against an arithmetic reference model.
module tb_align_shifter;
  import FPALL_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  fp_fmt_e     fmt;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] X;
  logic [4:0]  Shift_h;
  logic [4:0]  Shift_l;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] R;
  logic        Sticky_h;
  logic        Sticky_l;

  int n_cmp = 0;
  int n_bad = 0;
  logic [29:0] exp_q[$];

  align_shifter dut (
    .clk       (clk),
    .rst       (rst),
    .fmt       (fmt),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Shift_h   (Shift_h),
    .Shift_l   (Shift_l),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .Sticky_h  (Sticky_h),
    .Sticky_l  (Sticky_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One lane: result and OR of the bits that fall off, by plain masking.
  function automatic logic [14:0] ref_lane(input logic [13:0] v, input logic [4:0] s);
    logic [13:0] r;
    logic        st;
    if (s >= 5'd14) begin
      r  = '0;
      st = |v;
    end else begin
      r  = v >> s;
      st = |(v & ((14'd1 << s) - 14'd1));
    end
    return {st, r};
  endfunction

  // Returns {sticky_h, sticky_l, R}.
  function automatic logic [29:0] ref_align(input fp_fmt_e f, input logic [27:0] x,
                                            input logic [4:0] sh, input logic [4:0] sl);
    logic [27:0] r;
    logic        st_l;
    logic [14:0] hi;
    logic [14:0] lo;
    if (f == FP32) begin
      if (sl >= 5'd28) begin
        r    = '0;
        st_l = |x;
      end else begin
        r    = x >> sl;
        st_l = |(x & ((28'd1 << sl) - 28'd1));
      end
      return {1'b0, st_l, r};
    end
    hi = ref_lane(x[27:14], sh);
    lo = ref_lane(x[13:0], sl);
    return {hi[14], lo[14], hi[13:0], lo[13:0]};
  endfunction

  // Scoreboard: push on accept, pop and compare on emit.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 1'b0);
        end else begin
          logic [29:0] e;
          e = exp_q.pop_front();
          check("sb_R", R, e[27:0]);
          check("sb_Sticky_l", Sticky_l, e[28]);
          check("sb_Sticky_h", Sticky_h, e[29]);
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(ref_align(fmt, X, Shift_h, Shift_l));
    end
  end

  task automatic run_one(input string tag, input fp_fmt_e f, input logic [27:0] x,
                         input logic [4:0] sh, input logic [4:0] sl,
                         input logic [27:0] er, input logic eh, input logic el);
    @(posedge clk); #1;
    fmt = f; X = x; Shift_h = sh; Shift_l = sl; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_acc"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, out_valid, 1'b0);
    @(negedge clk);
    check({tag, "_lat2"}, out_valid, 1'b1);
    check({tag, "_R"}, R, er);
    check({tag, "_Sticky_h"}, Sticky_h, eh);
    check({tag, "_Sticky_l"}, Sticky_l, el);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [29:0] ea;
    logic        acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; fmt = FP32;
    X = '0; Shift_h = '0; Shift_l = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_R", R, 28'h0);
    check("rst_Sticky_h", Sticky_h, 1'b0);
    check("rst_Sticky_l", Sticky_l, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);

    run_one("fp32_sh4", FP32, 28'h8000001, 5'd0, 5'd4, 28'h0800000, 1'b0, 1'b1);
    run_one("fp32_sh31_one", FP32, 28'h0000001, 5'd0, 5'd31, 28'h0, 1'b0, 1'b1);
    run_one("fp32_sh31_zero", FP32, 28'h0000000, 5'd0, 5'd31, 28'h0, 1'b0, 1'b0);
    run_one("fp16_13_1", FP16X2, 28'h8000003, 5'd13, 5'd1, 28'h0004001, 1'b0, 1'b1);
    run_one("fp16_sh0", FP16X2, 28'hFFFFFFF, 5'd0, 5'd0, 28'hFFFFFFF, 1'b0, 1'b0);
    run_one("fp16_sh14", FP16X2, 28'h0010001, 5'd14, 5'd20, 28'h0, 1'b1, 1'b1);
    run_one("fp32_sh28", FP32, 28'h8000000, 5'd3, 5'd28, 28'h0, 1'b0, 1'b1);

    // Back-to-back stall: third offer must be refused until the pipe drains.
    ea = ref_align(FP16X2, 28'h1234567, 5'd3, 5'd9);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    fmt = FP16X2; X = 28'h1234567; Shift_h = 5'd3; Shift_l = 5'd9;
    @(negedge clk);
    check("bb_acc0", in_ready, 1'b1);
    @(posedge clk); #1;
    fmt = FP32; X = 28'hABCDEF1; Shift_l = 5'd17;
    @(negedge clk);
    check("bb_acc1", in_ready, 1'b1);
    @(posedge clk); #1;
    fmt = FP16X2; X = 28'h3FFF001; Shift_h = 5'd7; Shift_l = 5'd2;
    @(negedge clk);
    check("bb_full", in_ready, 1'b0);
    check("bb_R_first", R, ea[27:0]);
    @(posedge clk); #1;
    @(negedge clk);
    check("bb_hold_R", R, ea[27:0]);
    check("bb_hold_ready", in_ready, 1'b0);
    check("bb_hold_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bb_out0", out_valid, 1'b1);
    check("bb_acc2", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bb_out1", out_valid, 1'b1);
    @(negedge clk);
    check("bb_out2", out_valid, 1'b1);
    @(negedge clk);
    check("bb_idle", out_valid, 1'b0);

    // Reset with two entries in flight.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; fmt = FP32; X = 28'h00000FF; Shift_l = 5'd1;
    @(posedge clk); #1;
    X = 28'h0F0F0F0;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_R", R, 28'h0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("after_rst_out_valid", out_valid, 1'b0);
    check("after_rst_in_ready", in_ready, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("after_rst_no_stale", out_valid, 1'b0);
    end

    // Random mixed-format stream with random backpressure.
    acc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        fmt      = ($urandom_range(0, 1) != 0) ? FP16X2 : FP32;
        case ($urandom_range(0, 3))
          0:       X = '0;
          1:       X = 28'($urandom_range(0, 255));
          default: X = 28'($urandom());
        endcase
        Shift_h = 5'($urandom_range(0, 31));
        Shift_l = 5'($urandom_range(0, 31));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
    end

    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
